// File: rtl/usb3_rd_sched_pkg.sv
// Shared definitions for the FX3 slave-FIFO read scheduler: state codes and
// default geometry of the cache RAM banks it refills.
package usb3_rd_pkg;

   localparam int DEF_NUM_BANKS  = 16;
   localparam int DEF_BURST_LEN  = 256;
   localparam int DEF_RD_LATENCY = 3;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ARB       = 4'd1,
      ST_WAIT_FLAG = 4'd2,
      ST_SETUP     = 4'd3,
      ST_READ      = 4'd6,
      ST_DRAIN     = 4'd7,
      ST_DONE      = 4'd8
   } rd_state_e;

endpackage

// File: rtl/usb3_rd_sched_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr and grants the first
// one found, wrapping past the top bank.
module rr_arbiter
   import usb3_rd_pkg::*;
#(
   parameter int N  = DEF_NUM_BANKS,
   parameter int PW = 4
)(
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb3_rd_sched.sv
// Schedules FX3 slave-FIFO bursts into cache RAM banks: arbitrates bank refill
// requests, strobes BURST_LEN reads and writes the returned words to the bank.
module usb3_rd_sched
   import usb3_rd_pkg::*;
#(
   parameter int NUM_BANKS  = DEF_NUM_BANKS,
   parameter int BURST_LEN  = DEF_BURST_LEN,
   parameter int RD_LATENCY = DEF_RD_LATENCY
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 usb3_flaga,
   input  logic [31:0]          usb3_data,
   input  logic [NUM_BANKS-1:0] bank_req,
   output logic                 usb3_slrd_n,
   output logic                 usb3_sloe_n,
   output logic [3:0]           usb_rd_state,
   output logic [NUM_BANKS-1:0] wren_for_ram,
   output logic [7:0]           wr_addr,
   output logic [31:0]          ram_data,
   output logic [NUM_BANKS-1:0] bank_done
);

   localparam int          PTR_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [15:0] READ_LAST  = 16'(BURST_LEN - 1);
   localparam logic [15:0] DRAIN_LAST = 16'(RD_LATENCY - 1);
   localparam logic [7:0]  ADDR_LAST  = 8'(BURST_LEN - 1);

   rd_state_e              state;
   logic [NUM_BANKS-1:0]   grant;
   logic [NUM_BANKS-1:0]   arb_grant;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       grant_idx;
   logic [PTR_W-1:0]       next_ptr;
   logic [15:0]            cnt;
   logic [RD_LATENCY-1:0]  rd_pipe;

   assign usb_rd_state = state;

   rr_arbiter #(.N(NUM_BANKS), .PW(PTR_W)) u_arb (
      .req   (bank_req),
      .ptr   (rr_ptr),
      .grant (arb_grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (arb_grant[i]) grant_idx = PTR_W'(i);
      end
   end

   assign next_ptr = (grant_idx == PTR_W'(NUM_BANKS - 1)) ? '0 : grant_idx + PTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         usb3_slrd_n <= 1'b1;
         usb3_sloe_n <= 1'b1;
         bank_done   <= '0;
      end else begin
         bank_done <= '0;
         case (state)
            ST_IDLE: begin
               if (|bank_req) state <= ST_ARB;
            end
            ST_ARB: begin
               if (|arb_grant) begin
                  grant  <= arb_grant;
                  rr_ptr <= next_ptr;
                  state  <= ST_WAIT_FLAG;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT_FLAG: begin
               if (usb3_flaga) begin
                  state       <= ST_SETUP;
                  usb3_sloe_n <= 1'b0;
               end
            end
            ST_SETUP: begin
               state       <= ST_READ;
               usb3_slrd_n <= 1'b0;
               cnt         <= '0;
            end
            // The flag is deliberately ignored here: FX3 already promised a full burst.
            ST_READ: begin
               if (cnt == READ_LAST) begin
                  state       <= ST_DRAIN;
                  usb3_slrd_n <= 1'b1;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state       <= ST_DONE;
                  usb3_sloe_n <= 1'b1;
                  bank_done   <= grant;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_DONE: begin
               grant <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Each strobe travels RD_LATENCY stages to meet its word, then one more for ram_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe      <= '0;
         ram_data     <= '0;
         wren_for_ram <= '0;
         wr_addr      <= '0;
      end else begin
         rd_pipe[0] <= ~usb3_slrd_n;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         ram_data     <= usb3_data;
         wren_for_ram <= rd_pipe[RD_LATENCY-1] ? grant : '0;
         if (|wren_for_ram) begin
            wr_addr <= (wr_addr == ADDR_LAST) ? 8'd0 : wr_addr + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_usb3_rd_sched.sv
// Scoreboard bench for usb3_rd_sched with a small FX3 FIFO model that answers
// each read strobe RD_LATENCY cycles later with a tagged, indexed word.
module tb_usb3_rd_sched;
   import usb3_rd_pkg::*;

   localparam int NB = 16;
   localparam int BL = 256;
   localparam int RL = 3;

   typedef struct packed {
      logic [15:0] mask;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        usb3_flaga = 1'b0;
   logic [31:0] usb3_data = 32'h0BAD0BAD;
   logic [15:0] bank_req = '0;
   logic        usb3_slrd_n;
   logic        usb3_sloe_n;
   logic [3:0]  usb_rd_state;
   logic [15:0] wren_for_ram;
   logic [7:0]  wr_addr;
   logic [31:0] ram_data;
   logic [15:0] bank_done;

   wr_t         wr_q[$];
   logic [15:0] done_q[$];
   wr_t         mon_wr;
   logic [15:0] mon_done;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  tag = 8'h00;
   bit          const_mode = 1'b0;
   bit          abort_mode = 1'b0;

   bit          hist [RL+1];
   bit [15:0]   idxh [RL+1];
   bit [15:0]   strobe_idx = '0;

   usb3_rd_sched #(.NUM_BANKS(NB), .BURST_LEN(BL), .RD_LATENCY(RL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .usb3_flaga   (usb3_flaga),
      .usb3_data    (usb3_data),
      .bank_req     (bank_req),
      .usb3_slrd_n  (usb3_slrd_n),
      .usb3_sloe_n  (usb3_sloe_n),
      .usb_rd_state (usb_rd_state),
      .wren_for_ram (wren_for_ram),
      .wr_addr      (wr_addr),
      .ram_data     (ram_data),
      .bank_done    (bank_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // FX3 model: word for the strobe of cycle t is on the bus during cycle t+RL.
   always @(negedge clk) begin
      if (usb3_sloe_n) strobe_idx = '0;
      for (int j = RL; j > 0; j--) begin
         hist[j] = hist[j-1];
         idxh[j] = idxh[j-1];
      end
      hist[0] = !usb3_slrd_n;
      idxh[0] = strobe_idx;
      if (!usb3_slrd_n) strobe_idx = strobe_idx + 16'd1;
      usb3_data = hist[RL] ? (const_mode ? 32'hAAAAAAAA : {8'h5A, tag, idxh[RL]}) : 32'h0BAD0BAD;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (wren_for_ram != '0 && !abort_mode) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write wren %h addr %0d", wren_for_ram, wr_addr);
            end else begin
               mon_wr = wr_q.pop_front();
               check_output("wren_for_ram", 32'(wren_for_ram), 32'(mon_wr.mask));
               check_output("wr_addr", 32'(wr_addr), 32'(mon_wr.addr));
               check_output("ram_data", ram_data, mon_wr.data);
            end
         end
         if (bank_done != '0) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_bank_done got %h", bank_done);
            end else begin
               mon_done = done_q.pop_front();
               check_output("bank_done", 32'(bank_done), 32'(mon_done));
            end
         end
      end
   end

   task automatic push_burst(input logic [15:0] mask);
      wr_t e;
      for (int k = 0; k < BL; k++) begin
         e.mask = mask;
         e.addr = 8'(k);
         e.data = const_mode ? 32'hAAAAAAAA : {8'h5A, tag, 16'(k)};
         wr_q.push_back(e);
      end
      done_q.push_back(mask);
   endtask

   task automatic wait_dones(input int n, input int budget, output int low_cnt);
      int seen = 0;
      int cyc  = 0;
      low_cnt = 0;
      while (seen < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (!usb3_slrd_n) low_cnt++;
         if (bank_done != '0) seen++;
      end
      check_output("done_timeout", 32'(seen), 32'(n));
   endtask

   task automatic count_low(input int target, output int seen);
      int cyc = 0;
      seen = 0;
      while (seen < target && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (!usb3_slrd_n) seen++;
      end
      check_output("read_word_reached", 32'(seen), 32'(target));
   endtask

   task automatic check_reset_values();
      check_output("rst_state", 32'(usb_rd_state), 32'd0);
      check_output("rst_slrd_n", 32'(usb3_slrd_n), 32'd1);
      check_output("rst_sloe_n", 32'(usb3_sloe_n), 32'd1);
      check_output("rst_wren", 32'(wren_for_ram), 32'd0);
      check_output("rst_done", 32'(bank_done), 32'd0);
      check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_output("rst_ram_data", ram_data, 32'd0);
   endtask

   task automatic apply_stimulus();
      int low;
      int pre;
      int n;

      repeat (3) @(negedge clk);
      check_reset_values();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Three held requesters: grants 0, 2, 15, then back to 0.
      tag = 8'h01;
      usb3_flaga = 1'b1;
      push_burst(16'h0001);
      push_burst(16'h0004);
      push_burst(16'h8000);
      push_burst(16'h0001);
      bank_req = 16'h8005;
      wait_dones(4, 2000, low);
      bank_req = '0;
      check_output("rr_slrd_low_cycles", 32'(low), 32'(4 * BL));
      repeat (2) @(negedge clk);

      tag = 8'h02;
      push_burst(16'h0001);
      bank_req = 16'h0001;
      wait_dones(1, 600, low);
      bank_req = '0;
      check_output("single_slrd_low_cycles", 32'(low), 32'(BL));
      repeat (2) @(negedge clk);

      // Flag held low: scheduler parks in WAIT_FLAG (pointer now 1, so bank 2 wins).
      tag = 8'h03;
      usb3_flaga = 1'b0;
      push_burst(16'h0004);
      bank_req = 16'h0004;
      n = 0;
      while (usb_rd_state != 4'd2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_output("reach_wait_flag", 32'(usb_rd_state), 32'd2);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         check_output("wait_state", 32'(usb_rd_state), 32'd2);
         check_output("wait_slrd_n", 32'(usb3_slrd_n), 32'd1);
         check_output("wait_wren", 32'(wren_for_ram), 32'd0);
      end
      usb3_flaga = 1'b1;
      n = 0;
      while (usb3_slrd_n && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_output("flag_to_burst_cycles", 32'(n), 32'd2);
      wait_dones(1, 600, low);
      bank_req = '0;
      repeat (2) @(negedge clk);

      // Flag drops at word 100; the burst must still run to completion.
      const_mode = 1'b1;
      push_burst(16'h0008);
      bank_req = 16'h0008;
      count_low(100, pre);
      usb3_flaga = 1'b0;
      wait_dones(1, 600, low);
      bank_req = '0;
      check_output("flagdrop_slrd_low_cycles", 32'(pre + low), 32'(BL));
      usb3_flaga = 1'b1;
      const_mode = 1'b0;
      repeat (2) @(negedge clk);

      // Request withdrawn before ARB samples it: no grant, back to IDLE.
      bank_req = 16'h0002;
      @(negedge clk);
      bank_req = '0;
      check_output("empty_arb_state", 32'(usb_rd_state), 32'd1);
      @(negedge clk);
      check_output("empty_arb_idle", 32'(usb_rd_state), 32'd0);
      repeat (5) @(negedge clk);
      check_output("empty_arb_stays_idle", 32'(usb_rd_state), 32'd0);

      // Reset at read word 128, then a fresh full fill from address 0.
      tag = 8'h05;
      abort_mode = 1'b1;
      bank_req = 16'h0010;
      count_low(128, pre);
      rst_n = 1'b0;
      #1;
      check_reset_values();
      abort_mode = 1'b0;
      push_burst(16'h0010);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_dones(1, 600, low);
      bank_req = '0;
      check_output("post_reset_slrd_low_cycles", 32'(low), 32'(BL));

      repeat (20) @(negedge clk);
      check_output("writes_outstanding", 32'(wr_q.size()), 32'd0);
      check_output("dones_outstanding", 32'(done_q.size()), 32'd0);
   endtask

   initial begin
      apply_stimulus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb3_rd_sched.md
USB3_RD_SCHED -- requirements
Module: usb3_rd_sched

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 16, number of cache RAM banks served.
REQ-002 SHALL have parameter BURST_LEN, default 256, words per bank fill.
REQ-003 SHALL have parameter RD_LATENCY, default 3, cycles from usb3_slrd_n low to valid usb3_data.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port usb3_flaga  in  1  FX3 slave-FIFO watermark flag, 1 = at least BURST_LEN words available.
REQ-006 SHALL have port usb3_data  in  32  FX3 FIFO read data.
REQ-007 SHALL have port bank_req  in  NUM_BANKS  per-bank refill request, level, held until bank_done.
REQ-008 SHALL have ports: usb3_slrd_n  out  1  read strobe; usb3_sloe_n  out  1  output enable.
REQ-009 SHALL have port usb_rd_state  out  4  current state code.
REQ-010 SHALL have ports: wren_for_ram  out  NUM_BANKS  one-hot bank write enable; wr_addr  out  8  word address; ram_data  out  32  registered write data.
REQ-011 SHALL have port bank_done  out  NUM_BANKS  one-cycle fill-complete pulse per bank.

Function
REQ-012 SHALL implement states IDLE=0, ARB=1, WAIT_FLAG=2, SETUP=3, READ=6, DRAIN=7, DONE=8, driven on usb_rd_state.
REQ-013 SHALL go IDLE->ARB when any bank_req bit is 1; otherwise remain IDLE.
REQ-014 ARB SHALL grant exactly one requester round-robin, starting at the bank after the last granted (bank 0 after reset), latch the grant, then go WAIT_FLAG; ARB lasts exactly 1 cycle.
REQ-015 WAIT_FLAG SHALL hold until usb3_flaga=1, then go SETUP.
REQ-016 SETUP SHALL last 1 cycle with usb3_sloe_n=0, usb3_slrd_n=1.
REQ-017 READ SHALL drive usb3_slrd_n=0 for exactly BURST_LEN consecutive cycles, then go DRAIN.
REQ-018 usb3_flaga SHALL be ignored after leaving WAIT_FLAG; a flag drop during READ does not pause or abort the burst.
REQ-019 DRAIN SHALL last RD_LATENCY cycles with usb3_slrd_n=1, usb3_sloe_n=0, then go DONE.
REQ-020 usb3_sloe_n SHALL be 0 in SETUP, READ, DRAIN and 1 in all other states.
REQ-021 wren_for_ram SHALL assert only the granted bit, for exactly BURST_LEN cycles, starting RD_LATENCY+1 cycles after the first usb3_slrd_n low cycle (registered ram_data stage included).
REQ-022 ram_data SHALL be usb3_data registered once; wr_addr SHALL be 0 on the first wren cycle and increment by 1 each wren cycle, reaching BURST_LEN-1.
REQ-023 wr_addr SHALL return to 0 after the last write, with no wrap beyond BURST_LEN-1.
REQ-024 DONE SHALL pulse the granted bank_done bit for 1 cycle, clear the grant, then go IDLE.
REQ-025 bank_req changes while not in ARB SHALL not affect the current burst; the arbiter samples them at the next ARB.
REQ-026 A bank whose bank_req drops before ARB SHALL not be granted; if bank_req is all-zero when ARB is entered, go IDLE with no grant.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, usb3_slrd_n=1, usb3_sloe_n=1, wren_for_ram=0, bank_done=0, wr_addr=0, ram_data=0, usb_rd_state=0, and round-robin pointer to bank 0.
REQ-028 Reset asserted mid-READ SHALL abandon the burst with no bank_done; after release, operation restarts from IDLE.

Structure
REQ-029 State codes, NUM_BANKS, BURST_LEN and RD_LATENCY defaults SHALL reside in shared package usb3_rd_pkg.
REQ-030 Round-robin grant logic SHALL be sub-module rr_arbiter (request vector, pointer in; one-hot grant out).

Verification
REQ-031 bank_req=16'h0001, usb3_flaga=1 -> usb3_slrd_n low 256 cycles; wren_for_ram=16'h0001 for 256 cycles, wr_addr 0..255; bank_done[0] single pulse.
REQ-032 bank_req=16'h8005 held -> grants, in order, banks 0, 2, 15, 0.
REQ-033 usb3_flaga=0 for 50 cycles after ARB -> state stays 2, usb3_slrd_n=1, wren_for_ram=0; burst starts 2 cycles after flag rises.
REQ-034 usb3_data=32'hAAAAAAAA with usb3_flaga dropped at READ word 100 -> all 256 writes complete with ram_data=32'hAAAAAAAA.
REQ-035 rst_n pulsed low at READ word 128 -> all outputs at reset values within the cycle, no bank_done; next request completes a full 256-word fill from wr_addr 0.
